// File: rtl/wb_fta_bridge_mt_if.sv
// FTA bus types and the request/response interface used by wb_fta_bridge_mt.
package fta_pkg;
  typedef enum logic [4:0] {
    CMD_NONE  = 5'd0,
    CMD_LOAD  = 5'd1,
    CMD_STORE = 5'd2
  } fta_cmd_t;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tid_t;
endpackage

interface fta_bus_interface #(
  parameter int WID = 256
);
  import fta_pkg::*;

  typedef struct packed {
    logic             cyc;
    logic             we;
    fta_cmd_t         cmd;
    logic [WID/8-1:0] sel;
    logic [31:0]      adr;
    logic [WID-1:0]   data1;
    fta_tid_t         tid;
  } fta_req_t;

  typedef struct packed {
    logic           ack;
    logic           err;
    logic           rty;
    fta_tid_t       tid;
    logic [WID-1:0] dat;
  } fta_resp_t;

  fta_req_t  req;
  fta_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/wb_fta_bridge_mt.sv
// Wishbone-classic slave to FTA master bridge with tagged requests,
// retry handling, error reporting and late-response rejection.
// Optional watchdog enabled by defining WB_FTA_BRIDGE_TIMEOUT_EN.
module wb_fta_bridge_mt
  import fta_pkg::*;
#(
  parameter int         WID       = 256,
  parameter int         AWID      = 32,
  parameter logic [5:0] CORENO    = 6'd0,
  parameter logic [2:0] CHANNEL   = 3'd0,
  parameter int         MAX_RETRY = 3,
  parameter int         TO_CYCLES = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [WID/8-1:0] sel_i,
  input  logic [AWID-1:0]  adr_i,
  input  logic [WID-1:0]   dat_i,
  output logic             ack_o,
  output logic             err_o,
  output logic [WID-1:0]   dat_o,
  fta_bus_interface.master fta_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       seq_q;
  logic [7:0]       retry_q;
  logic             hold_we;
  logic [WID/8-1:0] hold_sel;
  logic [AWID-1:0]  hold_adr;
  logic [WID-1:0]   hold_dat;

  logic             issue, set_ack, set_err, clear_out, bump_seq, retry_up;
  logic             hit, rty_hit, first;
  logic             iss_we;
  logic [WID/8-1:0] iss_sel;
  logic [AWID-1:0]  iss_adr;
  logic [WID-1:0]   iss_dat;
  fta_tid_t         cur_tid;

`ifdef WB_FTA_BRIDGE_TIMEOUT_EN
  logic [15:0]      timer_q;
`endif

  assign cur_tid = '{core: CORENO, channel: CHANNEL, tranid: seq_q};
  // Only responses tagged with the live tid are considered; ack beats rty.
  assign hit     = fta_o.resp.ack && (fta_o.resp.tid == cur_tid);
  assign rty_hit = fta_o.resp.rty && !fta_o.resp.ack && (fta_o.resp.tid == cur_tid);

  // First issue takes the live bus inputs, reissues replay the held copy.
  assign first   = (state_q == IDLE);
  assign iss_we  = first ? we_i  : hold_we;
  assign iss_sel = first ? sel_i : hold_sel;
  assign iss_adr = first ? adr_i : hold_adr;
  assign iss_dat = first ? dat_i : hold_dat;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and action decode; a master abort in WAIT beats everything
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    set_ack   = 1'b0;
    set_err   = 1'b0;
    clear_out = 1'b0;
    bump_seq  = 1'b0;
    retry_up  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          bump_seq = 1'b1;
          state_d  = IDLE;
        end else if (hit) begin
          set_err = fta_o.resp.err;
          set_ack = !fta_o.resp.err;
          state_d = DONE;
        end else if (rty_hit) begin
          if (retry_q < 8'(MAX_RETRY)) begin
            issue    = 1'b1;
            retry_up = 1'b1;
          end else begin
            set_err = 1'b1;
            state_d = DONE;
          end
        end
`ifdef WB_FTA_BRIDGE_TIMEOUT_EN
        else if (timer_q >= 16'(TO_CYCLES - 1)) begin
          set_err = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (!cyc_i) begin
          clear_out = 1'b1;
          bump_seq  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request pulse, holding registers, sequence/retry counters and WB outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fta_o.req <= '0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      dat_o     <= '0;
      seq_q     <= '0;
      retry_q   <= '0;
      hold_we   <= 1'b0;
      hold_sel  <= '0;
      hold_adr  <= '0;
      hold_dat  <= '0;
    end else begin
      fta_o.req <= '0;
      if (issue) begin
        fta_o.req.cyc   <= 1'b1;
        fta_o.req.we    <= iss_we;
        fta_o.req.cmd   <= iss_we ? CMD_STORE : CMD_LOAD;
        fta_o.req.sel   <= iss_sel;
        fta_o.req.adr   <= 32'(iss_adr);
        fta_o.req.data1 <= iss_dat;
        fta_o.req.tid   <= cur_tid;
      end
      if (issue && first) begin
        hold_we  <= we_i;
        hold_sel <= sel_i;
        hold_adr <= adr_i;
        hold_dat <= dat_i;
        retry_q  <= '0;
      end else if (retry_up) begin
        retry_q <= retry_q + 8'd1;
      end
      if (set_ack) begin
        ack_o <= 1'b1;
        dat_o <= fta_o.resp.dat;
      end
      if (set_err) begin
        err_o <= 1'b1;
        dat_o <= '0;
      end
      if (clear_out) begin
        ack_o <= 1'b0;
        err_o <= 1'b0;
        dat_o <= '0;
      end
      if (bump_seq) seq_q <= seq_q + 4'd1;
    end
  end

`ifdef WB_FTA_BRIDGE_TIMEOUT_EN
  // Watchdog: counts WAIT clocks, restarts on every issue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          timer_q <= '0;
    else if (issue || state_q != WAIT)  timer_q <= '0;
    else                                timer_q <= timer_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wb_fta_bridge_mt.sv
// Self-checking bench for wb_fta_bridge_mt: directed scenarios plus a
// randomized transaction loop checked against a transaction-level model.
module tb_wb_fta_bridge_mt;
  import fta_pkg::*;

  localparam int WID  = 256;
  localparam int SW   = WID / 8;
  localparam int AWID = 32;
  localparam int MAXR = 3;
  localparam int TOC  = 20;
  localparam logic [5:0] CORE = 6'd5;
  localparam logic [2:0] CHAN = 3'd2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cyc, stb, we;
  logic [SW-1:0]  sel;
  logic [AWID-1:0] adr;
  logic [WID-1:0] dat_i;
  logic           ack, err;
  logic [WID-1:0] dat_o;

  fta_bus_interface #(.WID(WID)) fta ();

  wb_fta_bridge_mt #(
    .WID(WID), .AWID(AWID), .CORENO(CORE), .CHANNEL(CHAN),
    .MAX_RETRY(MAXR), .TO_CYCLES(TOC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat_i), .ack_o(ack), .err_o(err),
    .dat_o(dat_o), .fta_o(fta)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mseq  = 0;   // model of the bridge's transaction sequence number

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WID-1:0] rnd_w();
    logic [WID-1:0] r;
    for (int i = 0; i < WID / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send(input logic a, input logic e, input logic r,
                      input int tranid, input logic [WID-1:0] d);
    fta.resp.ack         = a;
    fta.resp.err         = e;
    fta.resp.rty         = r;
    fta.resp.tid.core    = CORE;
    fta.resp.tid.channel = CHAN;
    fta.resp.tid.tranid  = 4'(tranid);
    fta.resp.dat         = d;
  endtask

  task automatic quiet();
    fta.resp = '0;
  endtask

  task automatic start(input logic w, input logic [AWID-1:0] a,
                       input logic [SW-1:0] s, input logic [WID-1:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; dat_i = '0;
    quiet();
    step(); step();
    tests++;
    if ({ack, err, dat_o} !== '0) begin
      fails++; $display("FAIL reset_wb: got ack=%b err=%b dat=%h want 0", ack, err, dat_o);
    end
    tests++;
    if (fta.req !== '0) begin
      fails++; $display("FAIL reset_req: got cyc=%b adr=%h want all 0", fta.req.cyc, fta.req.adr);
    end
    rst = 1'b0;
    mseq = 0;
    step();
  endtask

  task automatic test_read();
    logic [WID-1:0] d = {SW{8'hA5}};
    start(1'b0, 32'h1000, '1, rnd_w());
    step();
    tests++;
    if (fta.req.cyc !== 1'b1 || fta.req.cmd !== CMD_LOAD || fta.req.we !== 1'b0 ||
        fta.req.adr !== 32'h1000 || fta.req.tid !== {CORE, CHAN, 4'(mseq)}) begin
      fails++; $display("FAIL read_issue: got cyc=%b cmd=%0d adr=%h tid=%h want 1 %0d 00001000 %h",
        fta.req.cyc, fta.req.cmd, fta.req.adr, fta.req.tid, CMD_LOAD, {CORE, CHAN, 4'(mseq)});
    end
    step();
    tests++;
    if (fta.req.cyc !== 1'b0) begin
      fails++; $display("FAIL read_pulse: got req.cyc=%b want 0", fta.req.cyc);
    end
    step();
    tests++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL read_early: got ack=%b err=%b want 0 0", ack, err);
    end
    send(1, 0, 0, mseq, d);
    step(); quiet();
    tests++;
    if (ack !== 1'b1 || err !== 1'b0 || dat_o !== d) begin
      fails++; $display("FAIL read_ack: got ack=%b err=%b dat=%h want 1 0 %h", ack, err, dat_o, d);
    end
    step();
    tests++;
    if (ack !== 1'b1 || dat_o !== d || fta.req.cyc !== 1'b0) begin
      fails++; $display("FAIL read_hold: got ack=%b req.cyc=%b dat=%h want 1 0 %h", ack, fta.req.cyc, dat_o, d);
    end
    cyc = 0; stb = 0;
    step();
    tests++;
    if (ack !== 1'b0 || dat_o !== '0) begin
      fails++; $display("FAIL read_clear: got ack=%b dat=%h want 0 0", ack, dat_o);
    end
    mseq = (mseq + 1) % 16;
  endtask

  // Also covers ack+rty together (ack wins) and write-data latching
  task automatic test_write();
    logic [WID-1:0] d  = {SW{8'h55}};
    logic [WID-1:0] rd = rnd_w();
    start(1'b1, 32'h2040, '1, d);
    step();
    tests++;
    if (fta.req.cyc !== 1'b1 || fta.req.cmd !== CMD_STORE || fta.req.we !== 1'b1 ||
        fta.req.data1 !== d || fta.req.sel !== '1 || fta.req.tid.tranid !== 4'(mseq)) begin
      fails++; $display("FAIL write_issue: got cmd=%0d data1=%h tranid=%0d want %0d %h %0d",
        fta.req.cmd, fta.req.data1, fta.req.tid.tranid, CMD_STORE, d, mseq);
    end
    step();
    send(1, 0, 1, mseq, rd);
    step(); quiet();
    tests++;
    if (ack !== 1'b1 || err !== 1'b0 || dat_o !== rd || fta.req.cyc !== 1'b0) begin
      fails++; $display("FAIL write_ack: got ack=%b err=%b req.cyc=%b dat=%h want 1 0 0 %h",
        ack, err, fta.req.cyc, dat_o, rd);
    end
    cyc = 0; stb = 0;
    step();
    mseq = (mseq + 1) % 16;
  endtask

  task automatic test_tag_filter();
    logic [WID-1:0] d = rnd_w();
    start(1'b0, $urandom, $urandom, rnd_w());
    step(); step();
    send(1, 0, 0, mseq + 1, rnd_w());
    step(); quiet();
    tests++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL tag_wrong: got ack=%b err=%b want 0 0", ack, err);
    end
    send(1, 0, 0, mseq, d);
    step(); quiet();
    tests++;
    if (ack !== 1'b1 || dat_o !== d) begin
      fails++; $display("FAIL tag_right: got ack=%b dat=%h want 1 %h", ack, dat_o, d);
    end
    cyc = 0; stb = 0;
    step();
    mseq = (mseq + 1) % 16;
  endtask

  task automatic test_retry();
    logic [AWID-1:0] ea = $urandom;
    logic [SW-1:0]   es = $urandom;
    logic [WID-1:0]  ed = rnd_w();
    int reissues = 0;
    start(1'b1, ea, es, ed);
    step();
    // Live inputs change after the first issue; reissues must replay the original
    adr = ~ea; sel = ~es; dat_i = ~ed; we = 1'b0;
    step();
    for (int r = 0; r <= MAXR; r++) begin
      send(0, 0, 1, mseq, '0);
      step(); quiet();
      if (fta.req.cyc === 1'b1) reissues++;
      if (r < MAXR) begin
        tests++;
        if (fta.req.cyc !== 1'b1 || fta.req.adr !== ea || fta.req.sel !== es ||
            fta.req.data1 !== ed || fta.req.cmd !== CMD_STORE || fta.req.tid.tranid !== 4'(mseq)) begin
          fails++; $display("FAIL retry_reissue%0d: got cyc=%b adr=%h sel=%h cmd=%0d want 1 %h %h %0d",
            r, fta.req.cyc, fta.req.adr, fta.req.sel, fta.req.cmd, ea, es, CMD_STORE);
        end
      end
    end
    tests++;
    if (reissues !== MAXR || err !== 1'b1 || ack !== 1'b0 || dat_o !== '0) begin
      fails++; $display("FAIL retry_exhaust: got reissues=%0d err=%b ack=%b want %0d 1 0", reissues, err, ack, MAXR);
    end
    cyc = 0; stb = 0;
    step();
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL retry_clear: got err=%b want 0", err);
    end
    mseq = (mseq + 1) % 16;
  endtask

  task automatic test_abort();
    int old;
    logic [WID-1:0] d = rnd_w();
    start(1'b0, $urandom, $urandom, rnd_w());
    step(); step();
    cyc = 0; stb = 0;
    step();
    tests++;
    if (ack !== 1'b0 || err !== 1'b0 || fta.req.cyc !== 1'b0) begin
      fails++; $display("FAIL abort_quiet: got ack=%b err=%b req.cyc=%b want 0 0 0", ack, err, fta.req.cyc);
    end
    old  = mseq;
    mseq = (mseq + 1) % 16;
    start(1'b0, $urandom, $urandom, rnd_w());
    step();
    tests++;
    if (fta.req.cyc !== 1'b1 || fta.req.tid.tranid !== 4'(mseq)) begin
      fails++; $display("FAIL abort_nextseq: got cyc=%b tranid=%0d want 1 %0d", fta.req.cyc, fta.req.tid.tranid, mseq);
    end
    step();
    send(1, 0, 0, old, rnd_w());
    step(); quiet();
    tests++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL abort_stale: got ack=%b err=%b want 0 0", ack, err);
    end
    send(1, 0, 0, mseq, d);
    step(); quiet();
    tests++;
    if (ack !== 1'b1 || dat_o !== d) begin
      fails++; $display("FAIL abort_next_ack: got ack=%b dat=%h want 1 %h", ack, dat_o, d);
    end
    cyc = 0; stb = 0;
    step();
    mseq = (mseq + 1) % 16;
  endtask

  task automatic test_reset_mid();
    start(1'b0, $urandom, $urandom, rnd_w());
    step(); step();
    rst = 1'b1;
    #1;
    tests++;
    if (ack !== 1'b0 || err !== 1'b0 || fta.req !== '0) begin
      fails++; $display("FAIL reset_mid: got ack=%b err=%b req.cyc=%b want 0 0 0", ack, err, fta.req.cyc);
    end
    cyc = 0; stb = 0;
    step();
    rst = 1'b0;
    mseq = 0;
    step();
    start(1'b1, $urandom, $urandom, rnd_w());
    step();
    tests++;
    if (fta.req.cyc !== 1'b1 || fta.req.tid.tranid !== 4'd0) begin
      fails++; $display("FAIL reset_seq: got cyc=%b tranid=%0d want 1 0", fta.req.cyc, fta.req.tid.tranid);
    end
    cyc = 0; stb = 0;
    step();
    mseq = 1;
  endtask

  // Random transactions: outcome predicted from the retry budget and final response
  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic            ew = 1'($urandom);
      logic [AWID-1:0] ea = $urandom;
      logic [SW-1:0]   es = $urandom;
      logic [WID-1:0]  ed = rnd_w();
      logic [WID-1:0]  rd = rnd_w();
      int nr  = $urandom_range(0, 4);
      int fin = $urandom_range(0, 2);
      int retries = 0;
      logic exp_err = 1'b0;
      logic ended = 1'b0;
      start(ew, ea, es, ed);
      step();
      tests++;
      if (fta.req.cyc !== 1'b1 || fta.req.we !== ew || fta.req.adr !== ea || fta.req.sel !== es ||
          fta.req.data1 !== ed || fta.req.tid.tranid !== 4'(mseq)) begin
        fails++; $display("FAIL rand%0d_issue: got adr=%h tranid=%0d want %h %0d", i, fta.req.adr, fta.req.tid.tranid, ea, mseq);
      end
      adr = $urandom; dat_i = rnd_w(); sel = $urandom;
      if (fin == 2) begin
        cyc = 0; stb = 0;
        step();
        tests++;
        if (ack !== 1'b0 || err !== 1'b0) begin
          fails++; $display("FAIL rand%0d_abort: got ack=%b err=%b want 0 0", i, ack, err);
        end
      end else begin
        for (int r = 0; r < nr && !ended; r++) begin
          send(1, 0, 0, mseq + 8, rnd_w());
          step();
          send(0, 0, 1, mseq, '0);
          step(); quiet();
          if (retries < MAXR) begin
            retries++;
            tests++;
            if (fta.req.cyc !== 1'b1 || fta.req.adr !== ea || fta.req.data1 !== ed) begin
              fails++; $display("FAIL rand%0d_reissue: got cyc=%b adr=%h want 1 %h", i, fta.req.cyc, fta.req.adr, ea);
            end
          end else begin
            exp_err = 1'b1;
            ended   = 1'b1;
          end
        end
        if (!ended) begin
          send(1, fin == 1, 0, mseq, rd);
          step(); quiet();
          exp_err = (fin == 1);
        end
        tests++;
        if (ack !== !exp_err || err !== exp_err || dat_o !== (exp_err ? '0 : rd)) begin
          fails++; $display("FAIL rand%0d_result: got ack=%b err=%b dat=%h want %b %b %h",
            i, ack, err, dat_o, !exp_err, exp_err, exp_err ? '0 : rd);
        end
        cyc = 0; stb = 0;
        step();
      end
      mseq = (mseq + 1) % 16;
    end
  endtask

`ifdef WB_FTA_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    start(1'b0, $urandom, $urandom, rnd_w());
    step();
    for (int k = 1; k < TOC; k++) step();
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL timeout_early: got err=%b want 0 at WAIT cycle %0d", err, TOC - 1);
    end
    step();
    tests++;
    if (err !== 1'b1 || ack !== 1'b0) begin
      fails++; $display("FAIL timeout_fire: got err=%b ack=%b want 1 0", err, ack);
    end
    for (int k = TOC + 1; k < 25; k++) step();
    send(1, 0, 0, mseq, rnd_w());
    step(); quiet();
    tests++;
    if (err !== 1'b1 || ack !== 1'b0) begin
      fails++; $display("FAIL timeout_late: got err=%b ack=%b want 1 0", err, ack);
    end
    cyc = 0; stb = 0;
    step();
    mseq = (mseq + 1) % 16;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_tag_filter();
    test_retry();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef WB_FTA_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
